// File: rtl/park_transform.sv
// Park rotation: Q15 alpha/beta plus electrical angle -> Q15 d/q currents.
// A quarter-wave sine ROM supplies sin/cos; a single signed 16x16 multiplier
// is shared over four cycles to build both 33-bit accumulators.
module park_transform #(
  parameter int LUT_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] i_alpha,
  input  logic [15:0] i_beta,
  input  logic [15:0] theta,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] i_d,
  output logic [15:0] i_q
);

  localparam int N  = 1 << LUT_BITS;
  localparam int AW = LUT_BITS + 1;  // ROM address width (0..N inclusive)
  localparam int PW = LUT_BITS + 2;  // retained phase bits: quadrant + index
  localparam logic [AW-1:0] NADDR = AW'(N);
  localparam longint PI_Q28 = 64'sd843314857;  // round(pi * 2^28)

  typedef enum logic [2:0] {
    IDLE, LUT, MUL0, MUL1, MUL2, MUL3, DONE
  } state_t;

  state_t state, state_nxt;

  // Elaboration-time table entry: round(32767*sin(k*pi/(2N))) using a
  // Q28 fixed-point Taylor series, end points pinned exactly.
  function automatic logic [15:0] sin_entry(input int k);
    longint x, x2, term, sum, r;
    if (k == 0) return 16'd0;
    if (k == N) return 16'd32767;
    x    = (longint'(k) * PI_Q28) >>> (LUT_BITS + 1);
    x2   = (x * x) >>> 28;
    term = x;
    sum  = x;
    for (int unsigned n = 1; n <= 10; n++) begin
      term = -((term * x2) >>> 28) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    r = (sum * 64'sd32767 + 64'sd134217728) >>> 28;
    return r[15:0];
  endfunction

  // Mirror the index for odd quadrants so only the first quarter is stored.
  function automatic logic [AW-1:0] fold_addr(input logic [PW-1:0] ph);
    logic [AW-1:0] idx;
    idx = {1'b0, ph[LUT_BITS-1:0]};
    return ph[LUT_BITS] ? (NADDR - idx) : idx;
  endfunction

  // Round half up to Q15 and clamp to the 16-bit signed range.
  function automatic logic [15:0] sat_q15(input logic signed [32:0] acc);
    logic signed [32:0] r;
    r = (acc + 33'sd16384) >>> 15;
    if (r > 33'sd32767)       return 16'h7fff;
    else if (r < -33'sd32768) return 16'h8000;
    else                      return r[15:0];
  endfunction

  logic signed [15:0] rom [0:N];

  for (genvar k = 0; k <= N; k++) begin : g_rom
    localparam logic [15:0] ENTRY = sin_entry(k);
    assign rom[k] = ENTRY;
  end

  logic signed [15:0] a_r, b_r, sin_r, cos_r;
  logic [PW-1:0]      ph_r;
  logic [PW-1:0]      cos_ph;
  logic [AW-1:0]      sin_addr, cos_addr;
  logic signed [15:0] sin_mag, cos_mag, sin_val, cos_val;
  logic signed [15:0] op_a, op_b;
  logic signed [31:0] prod;
  logic signed [32:0] prod_x;
  logic signed [32:0] acc_d, acc_q, acc_nxt;
  logic               theta_unused;

  // Angle bits below the ROM index are truncated and never looked at.
  assign theta_unused = ^theta[13-LUT_BITS:0];

  // Only the top PW angle bits are kept, so +pi/2 is +1 in the quadrant field.
  assign cos_ph = ph_r + PW'(N);

  // Quadrant-folded ROM lookup for both sin and cos of the captured angle.
  always_comb begin
    sin_addr = fold_addr(ph_r);
    cos_addr = fold_addr(cos_ph);
    sin_mag  = rom[sin_addr];
    cos_mag  = rom[cos_addr];
    sin_val  = ph_r[PW-1]   ? -sin_mag : sin_mag;
    cos_val  = cos_ph[PW-1] ? -cos_mag : cos_mag;
  end

  // Operand select for the shared multiplier, one product per MUL state.
  always_comb begin
    op_a = a_r;
    op_b = cos_r;
    case (state)
      MUL1: begin op_a = b_r; op_b = sin_r; end
      MUL2: begin op_a = a_r; op_b = sin_r; end
      MUL3: begin op_a = b_r; op_b = cos_r; end
      default: ;
    endcase
  end

  assign prod   = op_a * op_b;
  assign prod_x = {prod[31], prod};

  // Accumulator update: load, add, negated load, add.
  always_comb begin
    acc_nxt = '0;
    case (state)
      MUL0:    acc_nxt = prod_x;
      MUL1:    acc_nxt = acc_d + prod_x;
      MUL2:    acc_nxt = -prod_x;
      MUL3:    acc_nxt = acc_q + prod_x;
      default: acc_nxt = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: fixed walk through the multiply slots, hold in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = LUT;
      LUT:     state_nxt = MUL0;
      MUL0:    state_nxt = MUL1;
      MUL1:    state_nxt = MUL2;
      MUL2:    state_nxt = MUL3;
      MUL3:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath registers; i_q takes the final MUL3 sum directly so the result
  // is ready on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      ph_r  <= '0;
      sin_r <= '0;
      cos_r <= '0;
      acc_d <= '0;
      acc_q <= '0;
      i_d   <= '0;
      i_q   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r  <= i_alpha;
          b_r  <= i_beta;
          ph_r <= theta[15:14-LUT_BITS];
        end
        LUT: begin
          sin_r <= sin_val;
          cos_r <= cos_val;
        end
        MUL0, MUL1: acc_d <= acc_nxt;
        MUL2:       acc_q <= acc_nxt;
        MUL3: begin
          acc_q <= acc_nxt;
          i_d   <= sat_q15(acc_d);
          i_q   <= sat_q15(acc_nxt);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_park_transform.sv
// Directed bench for park_transform: hand-computed vectors, backpressure,
// mid-operation reset and a balanced 60 Hz sweep with tolerance checks.
module tb_park_transform;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] i_alpha   = '0;
  logic [15:0] i_beta    = '0;
  logic [15:0] theta     = '0;
  logic        in_ready, out_valid;
  logic [15:0] i_d, i_q;

  int checks   = 0;
  int failures = 0;
  int hs_count = 0;

  park_transform #(.LUT_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i_alpha   (i_alpha),
    .i_beta    (i_beta),
    .theta     (theta),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .i_d       (i_d),
    .i_q       (i_q)
  );

  always #5 clk = ~clk;

  // Count output handshakes as seen at the clock edge.
  always @(posedge clk) if (rst_n && out_valid && out_ready) hs_count++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input logic signed [31:0] obs,
                           input int lo, input int hi);
    checks++;
    assert ((obs >= lo && obs <= hi) === 1'b1) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=[%0d,%0d]", tag, obs, lo, hi);
    end
  endtask

  task automatic send(input int a, input int b, input int th);
    int n;
    i_alpha  = 16'(a);
    i_beta   = 16'(b);
    theta    = 16'(th);
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin step(); n++; end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
    chk({tag, "_valid"}, 32'(out_valid), 1);
  endtask

  task automatic do_sample(input string tag, input int a, input int b,
                           input int th, input int ed, input int eq);
    send(a, b, th);
    wait_out(tag);
    chk({tag, "_d"}, $signed(i_d), ed);
    chk({tag, "_q"}, $signed(i_q), eq);
    step();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    real wt;
    int  a, b, th, hs0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_i_d", $signed(i_d), 0);
    chk("rst_i_q", $signed(i_q), 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Test 1 with explicit latency
    i_alpha = 16'd16384; i_beta = 16'd0; theta = 16'd0; in_valid = 1'b1;
    chk("t1_in_ready_idle", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("t1_in_ready_busy", 32'(in_ready), 0);
    repeat (4) step();
    chk("t1_valid_early", 32'(out_valid), 0);
    step();
    chk("t1_valid_latency", 32'(out_valid), 1);
    chk("t1_d", $signed(i_d), 16384);
    chk("t1_q", $signed(i_q), 0);
    step();
    chk("t1_valid_cleared", 32'(out_valid), 0);
    chk("t1_in_ready_back", 32'(in_ready), 1);
    chk("t1_d_held", $signed(i_d), 16384);

    // Directed vectors
    do_sample("t2_quarter",   16384, -8192, 16'h4000, -8192, -16383);
    do_sample("t3_sat_pos",   32767, 32767, 16'h2000, 32767, 0);
    do_sample("sat_neg",     -32768, -32768, 16'h2000, -32768, 0);
    do_sample("trunc_idx",    16384, 0, 16'h003F, 16384, 0);

    // Test 4: backpressure holds result, blocks new input
    out_ready = 1'b0;
    send(-16384, 0, 0);
    wait_out("t4");
    chk("t4_d", $signed(i_d), -16383);
    chk("t4_q", $signed(i_q), 0);
    i_alpha = 16'd0; i_beta = 16'd16384; theta = 16'd0; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("t4_hold_valid", 32'(out_valid), 1);
      chk("t4_hold_d", $signed(i_d), -16383);
      chk("t4_hold_q", $signed(i_q), 0);
      chk("t4_hold_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    step();
    chk("t4_release_valid", 32'(out_valid), 0);
    chk("t4_release_in_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    wait_out("t4_next");
    chk("t4_next_d", $signed(i_d), 0);
    chk("t4_next_q", $signed(i_q), 16384);
    step();

    do_sample("q1_0x6000", 16384, 0, 16'h6000, -11585, -11585);
    do_sample("q3_0xE000", 0, 16384, 16'hE000, -11585, 11585);

    // Test 5: async reset during MUL1
    i_alpha = 16'd16384; i_beta = 16'd0; theta = 16'd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_in_ready", 32'(in_ready), 1);
    chk("t5_d", $signed(i_d), 0);
    chk("t5_q", $signed(i_q), 0);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("t5_no_partial", 32'(out_valid), 0);
    end
    do_sample("t5_after", 16384, 0, 0, 16384, 0);

    // Test 6: balanced sweep, back-to-back
    hs0 = hs_count;
    for (int n = 0; n < 1666; n++) begin
      wt = 2.0 * 3.141592653589793 * 0.003 * n;
      a  = int'(32767.0 * $cos(wt));
      b  = int'(32767.0 * $sin(wt));
      th = int'(196.608 * n) & 65535;
      send(a, b, th);
      wait_out("sweep");
      chk_range("sweep_d", $signed(i_d), 32547, 32767);
      chk_range("sweep_q", $signed(i_q), -220, 220);
      step();
    end
    chk("sweep_handshakes", hs_count - hs0, 1666);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
